mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 SHALL have port ifu_req_valid  input  1  IFU fetch request.
REQ-006 SHALL have port ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port ifu_resp_valid  output  1  fetch data valid, one-cycle pulse.
REQ-009 SHALL have port ifu_rdata  output  DATA_W  fetch data.
REQ-010 SHALL have port lsu_req_valid  input  1  load/store request.
REQ-011 SHALL have port lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-012 SHALL have port lsu_addr  input  ADDR_W  rdata1+imm address.
REQ-013 SHALL have port lsu_wen  input  1  1 = store, 0 = load.
REQ-014 SHALL have port lsu_size  input  2  00 byte, 01 half, 10 word (Mwen/Mren encoding); 11 is illegal.
REQ-015 SHALL have port lsu_wdata  input  DATA_W  store data (rdata2).
REQ-016 SHALL have port lsu_resp_valid  output  1  load data / store ack, one-cycle pulse.
REQ-017 SHALL have port lsu_rdata  output  DATA_W  load data.
REQ-018 SHALL have port mem_req_valid  output  1  request to shared memory.
REQ-019 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-020 SHALL have port mem_addr, mem_wen, mem_size, mem_wdata  output  ADDR_W/1/2/DATA_W  latched request fields.
REQ-021 SHALL have port mem_resp_valid  input  1  memory response strobe.
REQ-022 SHALL have port mem_rdata  input  DATA_W  memory read data.

Function
REQ-023 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; exactly one transaction outstanding.
REQ-024 SHALL, in IDLE, grant to the sole valid requester; when both are valid, grant to the one not granted last (round-robin, last_grant flag resets to IFU, so LSU wins first tie).
REQ-025 SHALL, on grant in IDLE, pulse the winner's req_ready for that cycle (combinational), latch addr/wen/size/wdata, and go to ISSUE next cycle.
REQ-026 SHALL force IFU requests to wen=0, size=10, wdata=0.
REQ-027 SHALL, in ISSUE, hold mem_req_valid=1 with stable latched fields until mem_req_ready=1, then go to WAIT.
REQ-028 SHALL, in WAIT, on mem_resp_valid=1, pass mem_rdata combinationally to the granted requester's rdata, pulse its resp_valid the same cycle, update last_grant, and return to IDLE.
REQ-029 SHALL drive non-granted resp_valid=0 and rdata=0; mem_resp_valid outside WAIT SHALL be ignored.
REQ-030 SHALL give stores a resp_valid ack; their rdata is don't-care.
REQ-031 SHALL have a minimum latency of accept at cycle 0, mem_req_valid at cycle 1, and resp at cycle 2 (ready at 1, resp at 2); back-to-back grant is possible in the cycle after the response.
REQ-032 SHALL never assert both req_ready outputs in the same cycle, or any req_ready outside IDLE.
REQ-033 SHALL treat lsu_size=11 as word.

Reset
REQ-034 SHALL, when rst=0, asynchronously enter IDLE, clear latches and last_grant (IFU), and drive all outputs to 0; any in-flight transaction is abandoned with no response.
REQ-035 SHALL, after deassertion, accept a new grant in the first IDLE cycle.

Structure
REQ-036 SHALL place the state enum (IDLE/ISSUE/WAIT) and size encodings (SZ_B/SZ_H/SZ_W) in shared package ysyx_23060042_pkg.
REQ-037 SHALL be a single module with no sub-modules; the round-robin choice SHALL be an inline function.

Verification
REQ-038 SHALL cover: IFU alone, addr 0x80000000, memory ready at once, rdata 0x00000413 one cycle later -> ifu_req_ready at c0, mem_req_valid at c1, ifu_resp_valid with 0x00000413 at c2.
REQ-039 SHALL cover: both valid from reset -> LSU granted first; while both remain valid, grants alternate IFU, LSU.
REQ-040 SHALL cover: LSU store addr 0x80001000, size 10, data 0xDEADBEEF, mem_req_ready held 0 for 3 cycles -> fields stable throughout, a single lsu_resp_valid pulse.
REQ-041 SHALL cover: mem_resp_valid pulsed in IDLE -> no resp_valid asserted.
REQ-042 SHALL cover: rst=0 asserted in WAIT -> all outputs 0 immediately; a late mem_resp_valid after release is ignored.

Source files
------------

// File: rtl/ysyx_23060042_pkg.sv
// rtl/ysyx_23060042_pkg.sv - shared state and access-size encodings for the memory arbiter
package ysyx_23060042_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // 2'b11 has no encoding of its own and is carried to memory as a word access
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    case (size)
      SZ_B:    return SZ_B;
      SZ_H:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter onto one shared memory port
module mem_arbiter
  import ysyx_23060042_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [1:0]        lsu_size,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  logic              r_sel_lsu;
  logic              r_last_lsu;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;

  logic w_idle;
  logic w_any;
  logic w_pick_lsu;
  logic w_resp;

  // A tie goes to whichever side did not complete the previous transaction
  function automatic logic pick_lsu(input logic ifu_v, input logic lsu_v, input logic last_lsu);
    if (ifu_v && lsu_v) return !last_lsu;
    return lsu_v;
  endfunction

  assign w_idle     = rst && (r_state == IDLE);
  assign w_any      = ifu_req_valid || lsu_req_valid;
  assign w_pick_lsu = pick_lsu(ifu_req_valid, lsu_req_valid, r_last_lsu);
  assign w_resp     = (r_state == WAIT) && mem_resp_valid;

  assign ifu_req_ready  = w_idle && w_any && !w_pick_lsu;
  assign lsu_req_ready  = w_idle && w_any && w_pick_lsu;
  assign ifu_resp_valid = w_resp && !r_sel_lsu;
  assign lsu_resp_valid = w_resp && r_sel_lsu;
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_size      = r_size;
  assign mem_wdata     = r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_sel_lsu       <= 1'b0;
      r_last_lsu      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_size          <= 2'b00;
      r_wdata         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state         <= ISSUE;
            r_mem_req_valid <= 1'b1;
            r_sel_lsu       <= w_pick_lsu;
            if (w_pick_lsu) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_size  <= norm_size(lsu_size);
              r_wdata <= lsu_wdata;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_size  <= SZ_W;
              r_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            r_state         <= WAIT;
            r_mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            r_state    <= IDLE;
            r_last_lsu <= r_sel_lsu;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with an autonomous memory responder
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req_valid = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [1:0]  lsu_size = 2'b10;
  logic [31:0] lsu_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        auto_ready = 1'b0, man_ready = 1'b0;
  logic        auto_resp = 1'b0, man_resp = 1'b0;
  logic        mem_req_ready, mem_resp_valid;

  logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic        mem_req_valid, mem_wen;
  logic [1:0]  mem_size;

  assign mem_req_ready  = auto_ready | man_ready;
  assign mem_resp_valid = auto_resp | man_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic is_lsu; logic chk_data; logic [31:0] data; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic wen; logic [1:0] size; logic [31:0] wdata; } req_t;

  resp_t       exp_resp_q[$];
  req_t        exp_req_q[$];
  logic [31:0] mem_data_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ready_delay = 0;
  bit          suppress_resp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, {ifu_req_ready, lsu_req_ready}, 0);
    chk({tag, "_mem_ctrl"}, {mem_req_valid, mem_wen, mem_size}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
    chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
  endtask

  task automatic wait_grant(output logic got_lsu, output int at_cyc);
    got_lsu = 1'b0;
    at_cyc  = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifu_req_ready || lsu_req_ready) begin
        got_lsu = lsu_req_ready;
        at_cyc  = cyc;
        return;
      end
    end
    chk("grant_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_resp_q.size() != 0; i++) @(posedge clk);
    chk("drain_resp_queue", exp_resp_q.size(), 0);
  endtask

  // Memory model: accepts after ready_delay stall cycles, answers the cycle after acceptance
  initial begin
    forever begin
      @(posedge clk); #1;
      auto_ready = 1'b0;
      auto_resp  = 1'b0;
      if (mem_req_valid) begin
        repeat (ready_delay) begin @(posedge clk); #1; end
        auto_ready = 1'b1;
        @(posedge clk); #1;
        auto_ready = 1'b0;
        if (!suppress_resp && mem_data_q.size() > 0) begin
          auto_resp = 1'b1;
          mem_rdata = mem_data_q.pop_front();
        end
      end
    end
  end

  initial begin
    resp_t e;
    req_t  r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ifu_req_ready || lsu_req_ready)
          chk("ready_exclusive", {ifu_req_ready, lsu_req_ready} == 2'b11, 0);
        if (mem_req_valid) begin
          chk("mem_req_expected", exp_req_q.size() > 0, 1);
          if (exp_req_q.size() > 0) begin
            r = exp_req_q[0];
            chk("mem_addr", mem_addr, r.addr);
            chk("mem_wen", mem_wen, r.wen);
            chk("mem_size", mem_size, r.size);
            chk("mem_wdata", mem_wdata, r.wdata);
            if (mem_req_ready) void'(exp_req_q.pop_front());
          end
        end
        if (ifu_resp_valid || lsu_resp_valid) begin
          chk("resp_onehot", ifu_resp_valid && lsu_resp_valid, 0);
          chk("resp_expected", exp_resp_q.size() > 0, 1);
          if (exp_resp_q.size() > 0) begin
            e = exp_resp_q.pop_front();
            chk("resp_port", lsu_resp_valid, e.is_lsu);
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_other_rdata", e.is_lsu ? ifu_rdata : lsu_rdata, 0);
            if (e.chk_data) chk("resp_data", e.is_lsu ? lsu_rdata : ifu_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got_lsu;
    logic        want_lsu;
    int          at, prev;
    logic [31:0] d;

    // Both requesters pending from reset: outputs held at zero, then LSU wins first tie
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b0;
    lsu_size      = 2'b11;
    lsu_wdata     = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      want_lsu = (g % 2 == 0);
      wait_grant(got_lsu, at);
      chk("grant_order", got_lsu, want_lsu);
      if (g > 0) chk("grant_spacing", at - prev, 3);
      prev = at;
      d = want_lsu ? 32'h2000_0000 + g : 32'h1000_0000 + g;
      if (want_lsu) exp_req_q.push_back('{32'h8000_2000, 1'b0, 2'b10, 32'h1234_5678});
      else          exp_req_q.push_back('{32'h8000_0100, 1'b0, 2'b10, 32'h0});
      mem_data_q.push_back(d);
      exp_resp_q.push_back('{want_lsu, 1'b1, d, at + 2});
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    drain();

    // IFU alone, minimum latency
    @(posedge clk); #1;
    ifu_addr      = 32'h8000_0000;
    ifu_req_valid = 1'b1;
    @(negedge clk);
    chk("ifu_ready_c0", ifu_req_ready, 1);
    exp_req_q.push_back('{32'h8000_0000, 1'b0, 2'b10, 32'h0});
    mem_data_q.push_back(32'h0000_0413);
    exp_resp_q.push_back('{1'b0, 1'b1, 32'h0000_0413, cyc + 2});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(negedge clk);
    chk("mem_req_valid_c1", mem_req_valid, 1);
    chk("ifu_ready_c1", ifu_req_ready, 0);
    drain();

    // LSU store with memory stalling three cycles; LSU keeps requesting during the stall
    ready_delay   = 3;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_size      = 2'b10;
    lsu_wdata     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lsu_req_valid = 1'b1;
    wait_grant(got_lsu, at);
    chk("store_grant", got_lsu, 1);
    exp_req_q.push_back('{32'h8000_1000, 1'b1, 2'b10, 32'hDEAD_BEEF});
    mem_data_q.push_back(32'h0);
    exp_resp_q.push_back('{1'b1, 1'b0, 32'h0, at + 5});
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ready_while_busy", {ifu_req_ready, lsu_req_ready}, 0);
      @(posedge clk); #1;
    end
    lsu_req_valid = 1'b0;
    drain();
    ready_delay = 0;
    lsu_wen     = 1'b0;

    // Stray memory response while idle
    @(posedge clk); #1;
    man_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp_ignored", {ifu_resp_valid, lsu_resp_valid}, 0);
    @(posedge clk); #1;
    man_resp = 1'b0;

    // Reset while waiting for the memory response
    suppress_resp = 1'b1;
    ifu_addr      = 32'h8000_0040;
    ifu_req_valid = 1'b1;
    wait_grant(got_lsu, at);
    chk("abort_grant", got_lsu, 0);
    exp_req_q.push_back('{32'h8000_0040, 1'b0, 2'b10, 32'h0});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_in_wait");
    @(posedge clk); #1;
    suppress_resp = 1'b0;
    rst           = 1'b1;
    man_resp      = 1'b1;
    ifu_addr      = 32'h8000_0080;
    ifu_req_valid = 1'b1;
    @(negedge clk);
    chk("late_resp_ignored", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("grant_after_reset", ifu_req_ready, 1);
    exp_req_q.push_back('{32'h8000_0080, 1'b0, 2'b10, 32'h0});
    mem_data_q.push_back(32'h00A0_0093);
    exp_resp_q.push_back('{1'b0, 1'b1, 32'h00A0_0093, cyc + 2});
    @(posedge clk); #1;
    man_resp      = 1'b0;
    ifu_req_valid = 1'b0;
    drain();
    chk("req_queue_empty", exp_req_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
